riscv_fetch_unit: RTL and testbench
===================================

// Module: riscv_fetch_unit
// PURPOSE
//  Instruction-fetch stage feeding the ID stage of riscv_core. Owns the fetch PC and drives SP_SRAM I-memory
//  (1-cycle synchronous read). Buffers returned words in a small fetch queue, so ID stalls and redirects
//  never lose or duplicate an instruction. Presents one {PC, instruction} pair per cycle to the IF/ID register.
// PARAMETERS
//  RESET_PC  32'h0000_0000  fetch address after reset; bits [1:0] must be 0
//  FQ_DEPTH  2              fetch-queue entries; power of two, >=2
// PORTS
//  CLK          in   1   clock; all state updates on posedge
//  RSTn         in   1   asynchronous active-low reset
//  I_MEM_CSN    out  1   I-mem chip select, active low
//  I_MEM_ADDR   out  32  I-mem byte address (word aligned)
//  I_MEM_DI     in   32  I-mem read data, valid 1 cycle after the request
//  ID_STALL     in   1   ID cannot accept this cycle (load-use/branch stall)
//  REDIRECT     in   1   branch/jump resolved taken; flush and refetch
//  REDIRECT_PC  in   32  new fetch address; bits [1:0] ignored (forced 0)
//  IF_VALID     out  1   IF_INST/IF_PC are valid
//  IF_INST      out  32  instruction at queue head
//  IF_PC        out  32  PC of IF_INST
// BEHAVIOUR
//  State: fetch_pc, pending (request issued last cycle), FQ_DEPTH-entry queue {pc,inst}, count, kill.
//  Reset (async, RSTn=0): fetch_pc=RESET_PC, pending=0, count=0, kill=0. Outputs: I_MEM_CSN=1,
//   IF_VALID=0, IF_INST=32'h0000_0013 (NOP), IF_PC=0. Same clear on reset mid-operation; any in-flight read is dropped.
//  pop = IF_VALID & ~ID_STALL & ~REDIRECT. IF outputs are combinational from the queue head.
//   Empty queue: IF_VALID=0, IF_INST=NOP, IF_PC=0.
//  issue = RSTn & (count + pending - pop < FQ_DEPTH), or REDIRECT (always issues).
//   I_MEM_CSN = ~issue. I_MEM_ADDR = REDIRECT ? {REDIRECT_PC[31:2],2'b00} : fetch_pc.
//  On issue: fetch_pc <= I_MEM_ADDR + 4 (mod 2^32; wraps 0xFFFF_FFFC -> 0). Record the issued
//   address as pending_pc. pending <= issue.
//  Response: if pending & ~kill & ~REDIRECT, push {pending_pc, I_MEM_DI} at tail.
//   Push and pop in the same cycle: count unchanged.
//  REDIRECT (highest priority): count<=0, queue flushed, the pending response for the old path is
//   discarded. The new request issues this cycle, so its word appears in the queue next cycle
//   and IF_VALID rises 2 cycles after REDIRECT (1 bubble to ID).
//  ID_STALL with the queue full: issue=0 and no push. Head held stable (IF_INST/IF_PC unchanged).
//   Not-full: issuing continues until count+pending reaches FQ_DEPTH.
//  Steady state with no stalls: 1 instruction/cycle, first IF_VALID 2 cycles after RSTn deasserts.
//  Queue never overflows: the issue rule reserves a slot for every pending response.
//   Overflow/underflow = RTL bug; bench asserts on it.
// CONFIGURATION
//  IF_PERF_CNT_EN defined: adds outputs PERF_FETCHED[31:0] (pushes), PERF_SQUASHED[31:0]
//   (queue entries + live pending discarded per REDIRECT, summed), PERF_STALL_CYC[31:0] (cycles
//   with IF_VALID & ID_STALL). All reset to 0 asynchronously and wrap at 2^32.
//  Not defined: ports and counters absent. Fetch behaviour identical.
// TESTING
//  1 Reset, RESET_PC=0, sequential I-mem, no stalls -> IF_VALID at cycle 2, IF_PC 0,4,8,... one per
//    cycle, IF_INST = mem[IF_PC>>2].
//  2 ID_STALL held 5 cycles while IF_PC=0x8 -> IF_PC/IF_INST stay 0x8 for all 5. Then 0xC next cycle,
//    no skipped or duplicated PCs. I_MEM_CSN=1 once count+pending=2.
//  3 REDIRECT=1, REDIRECT_PC=0x40 while IF_PC=0x10 -> I_MEM_ADDR=0x40 same cycle. IF_VALID=0 next cycle,
//    then IF_PC=0x40, 0x44. PCs 0x14/0x18 never presented.
//  4 REDIRECT and ID_STALL same cycle, REDIRECT_PC=0x43 -> fetch from 0x40. Stall ignored for the flush.
//  5 REDIRECT_PC=0xFFFF_FFFC -> IF_PC 0xFFFF_FFFC then 0x0000_0000 (wrap).
//  6 RSTn pulsed low mid-stream with queue full -> I_MEM_CSN=1 and IF_VALID=0 immediately. After release, refetch from
//    RESET_PC. With IF_PERF_CNT_EN, test 3 gives PERF_SQUASHED += count+pending at redirect.

Source files
------------

// File: rtl/riscv_fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, drives the synchronous I-memory and buffers returned words.
// Optional build macro IF_PERF_CNT_EN adds fetch/squash/stall performance counters.
module riscv_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          FQ_DEPTH = 2
) (
    input  logic        CLK,
    input  logic        RSTn,
    output logic        I_MEM_CSN,
    output logic [31:0] I_MEM_ADDR,
    input  logic [31:0] I_MEM_DI,
    input  logic        ID_STALL,
    input  logic        REDIRECT,
    input  logic [31:0] REDIRECT_PC,
    output logic        IF_VALID,
    output logic [31:0] IF_INST,
    output logic [31:0] IF_PC
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] PERF_FETCHED,
    output logic [31:0] PERF_SQUASHED,
    output logic [31:0] PERF_STALL_CYC
`endif
);
    localparam int          PW  = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
    localparam int          CW  = PW + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   pending_pc_q, pending_pc_d;
    logic          pending_q, pending_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [31:0]   fq_pc_q [FQ_DEPTH];
    logic [31:0]   fq_pc_d [FQ_DEPTH];
    logic [31:0]   fq_inst_q [FQ_DEPTH];
    logic [31:0]   fq_inst_d [FQ_DEPTH];

    logic          pop, push, issue, room;
    logic [CW:0]   occ;
    logic [31:0]   redirect_addr;

    always_comb begin
        redirect_addr = REDIRECT_PC & ~32'h3;
        IF_VALID      = (count_q != '0);
        IF_INST       = IF_VALID ? fq_inst_q[head_q] : NOP;
        IF_PC         = IF_VALID ? fq_pc_q[head_q] : 32'h0;
        pop           = IF_VALID & ~ID_STALL & ~REDIRECT;
        // Slots already claimed (buffered + in flight) after this cycle's pop.
        occ           = {1'b0, count_q} + (CW+1)'(pending_q) - (CW+1)'(pop);
        room          = (occ < (CW+1)'(FQ_DEPTH));
        issue         = RSTn & (REDIRECT | room);
        I_MEM_CSN     = ~issue;
        I_MEM_ADDR    = REDIRECT ? redirect_addr : fetch_pc_q;
        push          = pending_q & ~REDIRECT;
    end

    always_comb begin
        fetch_pc_d   = issue ? I_MEM_ADDR + 32'd4 : fetch_pc_q;
        pending_pc_d = issue ? I_MEM_ADDR : pending_pc_q;
        pending_d    = issue;
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        fq_pc_d      = fq_pc_q;
        fq_inst_d    = fq_inst_q;
        if (REDIRECT) begin
            // Flush: the old-path response arriving this cycle is simply not pushed.
            count_d = '0;
            head_d  = tail_q;
        end else begin
            if (push) begin
                fq_pc_d[tail_q]   = pending_pc_q;
                fq_inst_d[tail_q] = I_MEM_DI;
                tail_d            = tail_q + PW'(1);
            end
            if (pop) begin
                head_d = head_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            fetch_pc_q   <= RESET_PC;
            pending_pc_q <= RESET_PC;
            pending_q    <= 1'b0;
            count_q      <= '0;
            head_q       <= '0;
            tail_q       <= '0;
        end else begin
            fetch_pc_q   <= fetch_pc_d;
            pending_pc_q <= pending_pc_d;
            pending_q    <= pending_d;
            count_q      <= count_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
        end
    end

    always_ff @(posedge CLK) begin
        fq_pc_q   <= fq_pc_d;
        fq_inst_q <= fq_inst_d;
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_squashed_q, perf_squashed_d;
    logic [31:0] perf_stall_cyc_q, perf_stall_cyc_d;

    always_comb begin
        perf_fetched_d   = perf_fetched_q + 32'(push);
        perf_squashed_d  = perf_squashed_q;
        if (REDIRECT) begin
            perf_squashed_d = perf_squashed_q + 32'(count_q) + 32'(pending_q);
        end
        perf_stall_cyc_d = perf_stall_cyc_q + 32'(IF_VALID & ID_STALL);
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            perf_fetched_q   <= 32'h0;
            perf_squashed_q  <= 32'h0;
            perf_stall_cyc_q <= 32'h0;
        end else begin
            perf_fetched_q   <= perf_fetched_d;
            perf_squashed_q  <= perf_squashed_d;
            perf_stall_cyc_q <= perf_stall_cyc_d;
        end
    end

    assign PERF_FETCHED   = perf_fetched_q;
    assign PERF_SQUASHED  = perf_squashed_q;
    assign PERF_STALL_CYC = perf_stall_cyc_q;
`endif

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Bench for riscv_fetch_unit: scripted vector table, randomized stall/redirect traffic
// against a stream-level reference model, and a mid-stream reset.
module tb_riscv_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          FQ_DEPTH = 2;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        CLK = 1'b0;
    logic        RSTn = 1'b0;
    logic        I_MEM_CSN;
    logic [31:0] I_MEM_ADDR;
    logic [31:0] I_MEM_DI = 32'h0;
    logic        ID_STALL = 1'b0;
    logic        REDIRECT = 1'b0;
    logic [31:0] REDIRECT_PC = 32'h0;
    logic        IF_VALID;
    logic [31:0] IF_INST;
    logic [31:0] IF_PC;
`ifdef IF_PERF_CNT_EN
    logic [31:0] PERF_FETCHED, PERF_SQUASHED, PERF_STALL_CYC;
`endif

    riscv_fetch_unit #(.RESET_PC(RESET_PC), .FQ_DEPTH(FQ_DEPTH)) dut (
        .CLK         (CLK),
        .RSTn        (RSTn),
        .I_MEM_CSN   (I_MEM_CSN),
        .I_MEM_ADDR  (I_MEM_ADDR),
        .I_MEM_DI    (I_MEM_DI),
        .ID_STALL    (ID_STALL),
        .REDIRECT    (REDIRECT),
        .REDIRECT_PC (REDIRECT_PC),
        .IF_VALID    (IF_VALID),
        .IF_INST     (IF_INST),
        .IF_PC       (IF_PC)
`ifdef IF_PERF_CNT_EN
        ,
        .PERF_FETCHED   (PERF_FETCHED),
        .PERF_SQUASHED  (PERF_SQUASHED),
        .PERF_STALL_CYC (PERF_STALL_CYC)
`endif
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Synchronous-read instruction memory: data one cycle after a selected request.
    always @(posedge CLK) begin
        if (!I_MEM_CSN) I_MEM_DI <= memfn(I_MEM_ADDR);
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Stream-level model: words buffered, word in flight, next PC ID should see, next PC to request.
    int          m_buf, m_infl;
    logic [31:0] m_head, m_next_req;
    logic        m_valid, m_pop, m_issue, m_redir, m_stall;
    logic [31:0] m_raddr;
    logic [31:0] m_fetched, m_squashed, m_stallcyc;

    task automatic model_reset();
        m_buf = 0; m_infl = 0;
        m_head = RESET_PC; m_next_req = RESET_PC;
        m_fetched = 0; m_squashed = 0; m_stallcyc = 0;
    endtask

    task automatic drive_check(input logic s, input logic r, input logic [31:0] rpc);
        ID_STALL = s; REDIRECT = r; REDIRECT_PC = rpc;
        #1;
        m_valid = (m_buf > 0);
        m_pop   = m_valid && !s && !r;
        m_issue = r || ((m_buf + m_infl - (m_pop ? 1 : 0)) < FQ_DEPTH);
        m_redir = r;
        m_stall = s;
        m_raddr = rpc & ~32'h3;
        chk("if_valid", IF_VALID, m_valid);
        chk("if_pc", IF_PC, m_valid ? m_head : 32'h0);
        chk("if_inst", IF_INST, m_valid ? memfn(m_head) : NOP);
        chk("csn", I_MEM_CSN, !m_issue);
        if (m_issue) chk("addr", I_MEM_ADDR, r ? m_raddr : m_next_req);
`ifdef IF_PERF_CNT_EN
        chk("perf_fetched", PERF_FETCHED, m_fetched);
        chk("perf_squashed", PERF_SQUASHED, m_squashed);
        chk("perf_stall", PERF_STALL_CYC, m_stallcyc);
`endif
    endtask

    task automatic clock();
        @(posedge CLK);
        if (m_infl > 0 && !m_redir) m_fetched++;
        if (m_redir) m_squashed += m_buf + m_infl;
        if (m_valid && m_stall) m_stallcyc++;
        if (m_redir) begin
            m_buf = 0; m_infl = 1;
            m_head = m_raddr; m_next_req = m_raddr + 32'd4;
        end else begin
            m_buf = m_buf + m_infl - (m_pop ? 1 : 0);
            if (m_pop) m_head = m_head + 32'd4;
            if (m_issue) m_next_req = m_next_req + 32'd4;
            m_infl = m_issue ? 1 : 0;
        end
        @(negedge CLK);
    endtask

    typedef struct {
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic        exp_csn;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t tbl[21];

    function automatic vec_t mk(input logic s, input logic r, input logic [31:0] rpc, input logic v,
                                input logic [31:0] pc, input logic csn, input logic [31:0] addr);
        vec_t t;
        t.stall = s; t.redir = r; t.rpc = rpc; t.exp_valid = v;
        t.exp_pc = pc; t.exp_csn = csn; t.exp_addr = addr;
        return t;
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_csn"}, I_MEM_CSN, 1'b1);
        chk({tag, "_valid"}, IF_VALID, 1'b0);
        chk({tag, "_inst"}, IF_INST, NOP);
        chk({tag, "_pc"}, IF_PC, 32'h0);
`ifdef IF_PERF_CNT_EN
        chk({tag, "_perf_fetched"}, PERF_FETCHED, 32'h0);
        chk({tag, "_perf_squashed"}, PERF_SQUASHED, 32'h0);
`endif
    endtask

    initial begin
        tbl[0]  = mk(0, 0, 32'h0,         0, 32'h0,         0, 32'h0);
        tbl[1]  = mk(0, 0, 32'h0,         0, 32'h0,         0, 32'h4);
        tbl[2]  = mk(0, 0, 32'h0,         1, 32'h0,         0, 32'h8);
        tbl[3]  = mk(0, 0, 32'h0,         1, 32'h4,         0, 32'hC);
        for (int i = 4; i <= 8; i++)
            tbl[i] = mk(1, 0, 32'h0,      1, 32'h8,         1, 32'h0);
        tbl[9]  = mk(0, 0, 32'h0,         1, 32'h8,         0, 32'h10);
        tbl[10] = mk(0, 0, 32'h0,         1, 32'hC,         0, 32'h14);
        tbl[11] = mk(0, 1, 32'h40,        1, 32'h10,        0, 32'h40);
        tbl[12] = mk(0, 0, 32'h0,         0, 32'h0,         0, 32'h44);
        tbl[13] = mk(0, 0, 32'h0,         1, 32'h40,        0, 32'h48);
        tbl[14] = mk(1, 1, 32'h43,        1, 32'h44,        0, 32'h40);
        tbl[15] = mk(1, 0, 32'h0,         0, 32'h0,         0, 32'h44);
        tbl[16] = mk(0, 0, 32'h0,         1, 32'h40,        0, 32'h48);
        tbl[17] = mk(0, 1, 32'hFFFF_FFFC, 1, 32'h44,        0, 32'hFFFF_FFFC);
        tbl[18] = mk(0, 0, 32'h0,         0, 32'h0,         0, 32'h0);
        tbl[19] = mk(0, 0, 32'h0,         1, 32'hFFFF_FFFC, 0, 32'h4);
        tbl[20] = mk(0, 0, 32'h0,         1, 32'h0,         0, 32'h8);

        // Power-on reset.
        @(negedge CLK);
        #1;
        check_reset_outputs("reset");
        @(negedge CLK);
        @(negedge CLK);
        RSTn = 1'b1;
        model_reset();

        // Scripted sequence: startup, 5-cycle stall, redirects, stall+redirect, address wrap.
        for (int i = 0; i < 21; i++) begin
            drive_check(tbl[i].stall, tbl[i].redir, tbl[i].rpc);
            chk($sformatf("tbl%0d_valid", i), IF_VALID, tbl[i].exp_valid);
            chk($sformatf("tbl%0d_pc", i), IF_PC, tbl[i].exp_valid ? tbl[i].exp_pc : 32'h0);
            chk($sformatf("tbl%0d_inst", i), IF_INST,
                tbl[i].exp_valid ? memfn(tbl[i].exp_pc) : NOP);
            chk($sformatf("tbl%0d_csn", i), I_MEM_CSN, tbl[i].exp_csn);
            if (!tbl[i].exp_csn) chk($sformatf("tbl%0d_addr", i), I_MEM_ADDR, tbl[i].exp_addr);
            clock();
        end

        // Randomized stall/redirect traffic.
        for (int c = 0; c < 1500; c++) begin
            logic        s, r;
            logic [31:0] rpc;
            s   = ($urandom_range(0, 99) < 30);
            r   = ($urandom_range(0, 99) < 8);
            rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                              : 32'($urandom);
            drive_check(s, r, rpc);
            clock();
        end

        // Fill the queue under stall, then pulse reset mid-stream.
        for (int c = 0; c < 4; c++) begin
            drive_check(1'b1, 1'b0, 32'h0);
            clock();
        end
        chk("full_before_reset", IF_VALID, 1'b1);
        RSTn = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(negedge CLK);
        @(negedge CLK);
        ID_STALL = 1'b0;
        RSTn = 1'b1;
        model_reset();
        for (int c = 0; c < 12; c++) begin
            drive_check(1'b0, 1'b0, 32'h0);
            if (c == 2) chk("refetch_pc", IF_PC, RESET_PC);
            clock();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
